fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: reset PC, NOP encoding, fetch buffer entry.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {inst, pc}; flush wins over push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{inst: NOP_INST, pc: '0};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= fetch_entry_t'(wr_data_i);
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch with redirect/discard handling and a 2-entry buffer.
// Optional perf counters (perf_fetched, perf_bubble) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      pc_q, pc_d;
  logic             fifo_empty;
  logic             credit_ok;
  logic             accept;
  logic             rsp_hit;
  logic             rsp_drop;
  logic             push;
  logic             pop;

  // Responses return in order and discards precede live ones, so a kept
  // response always belongs to pc_q minus the live outstanding count.
  always_comb begin
    credit_ok      = (32'(out_q) + 32'(fifo_count)) < BUF_DEPTH;
    imem_req_valid = rst_n && !redirect_valid && credit_ok;
    accept         = imem_req_valid && imem_req_ready;
    rsp_hit        = imem_rsp_valid && (out_q != '0);
    rsp_drop       = rsp_hit && (disc_q != '0);
    push           = rsp_hit && !rsp_drop && !redirect_valid;
    pop            = !fifo_empty && id_ready && !redirect_valid;
    wr_entry.inst  = imem_rsp_data;
    wr_entry.pc    = pc_q - (32'(out_q) << 2);
    out_d          = out_q + CNT_W'(accept) - CNT_W'(rsp_hit);
    disc_d         = disc_q - CNT_W'(rsp_drop);
    pc_d           = accept ? pc_q + 32'd4 : pc_q;
    if (redirect_valid) begin
      disc_d = out_d;
      pc_d   = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      disc_q <= '0;
      pc_q   <= RESET_PC;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
      pc_q   <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (redirect_valid),
    .wr_data_i (wr_entry),
    .rd_data_o (rd_entry),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  assign imem_req_addr = pc_q;
  assign id_valid      = !fifo_empty;
  assign id_inst       = rd_entry.inst;
  assign id_pc         = rd_entry.pc;
  assign id_pc4        = rd_entry.pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (id_ready && fifo_empty) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with queued responses, expected PC stream, credit bound.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubble    (perf_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;

  // memory model: accepted requests in order, with accept cycle and "discarded" tag
  logic [31:0] mq_addr [$];
  int unsigned mq_cyc  [$];
  bit          mq_dead [$];

  bit          rnd;
  bit          hold_id;
  bit          mem_stall;
  bit          force_redir;
  logic [31:0] force_pc;

  logic [31:0] next_req_pc;
  logic [31:0] exp_pc;
  int          live;
  int          dead;
  bit          redir_prev;
  bit          id_hold_prev;
  logic [31:0] id_hold_inst;
  logic [31:0] id_hold_pc;
  logic [31:0] acc_log [$];
  logic [31:0] hs_pc   [$];
  int unsigned hs_cyc  [$];
  int unsigned m_fetched;
  int unsigned m_bubble;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // input drive for the current cycle, just after the rising edge
  task automatic drive();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mq_addr.size() != 0 && mq_cyc[0] < cyc && !mem_stall &&
        (!rnd || $urandom_range(0, 2) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
      if (mq_dead[0]) dead--;
      void'(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
      void'(mq_dead.pop_front());
    end else if (rnd && mq_addr.size() == 0 && $urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    id_ready       = hold_id ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if (rnd && $urandom_range(0, 24) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
    end
  endtask

  // checks and model update for the edge that closes the current cycle
  task automatic sample();
    bit hs;
    if (redir_prev) check("idv_after_redir", 32'(id_valid), 32'd0);
    if (imem_req_valid) check("req_addr", imem_req_addr, next_req_pc);
    if (id_valid && id_hold_prev) begin
      check("id_inst_hold", id_inst, id_hold_inst);
      check("id_pc_hold", id_pc, id_hold_pc);
    end
    hs = id_valid && id_ready && !redirect_valid;
    if (hs) begin
      check("id_pc", id_pc, exp_pc);
      check("id_inst", id_inst, mem_word(exp_pc));
      check("id_pc4", id_pc4, exp_pc + 32'd4);
      hs_pc.push_back(id_pc);
      hs_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
      live--;
      m_fetched++;
    end
    if (id_ready && !id_valid) m_bubble++;
    id_hold_prev = id_valid && !id_ready && !redirect_valid;
    id_hold_inst = id_inst;
    id_hold_pc   = id_pc;
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_cyc.push_back(cyc);
      mq_dead.push_back(1'b0);
      acc_log.push_back(imem_req_addr);
      live++;
      next_req_pc = next_req_pc + 32'd4;
    end
    if (redirect_valid) begin
      check("req_off_redir", 32'(imem_req_valid), 32'd0);
      foreach (mq_dead[i]) begin
        if (!mq_dead[i]) begin
          mq_dead[i] = 1'b1;
          dead++;
        end
      end
      live        = 0;
      next_req_pc = {redirect_pc[31:2], 2'b00};
      exp_pc      = next_req_pc;
    end
    check("credit_le2", 32'((live + dead) > 2), 32'd0);
    redir_prev = redirect_valid;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mq_addr.delete();
    mq_cyc.delete();
    mq_dead.delete();
    acc_log.delete();
    hs_pc.delete();
    hs_cyc.delete();
    live = 0;
    dead = 0;
    next_req_pc  = RST_PC;
    exp_pc       = RST_PC;
    redir_prev   = 1'b0;
    id_hold_prev = 1'b0;
    force_redir  = 1'b0;
    m_fetched    = 0;
    m_bubble     = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_inst", id_inst, NOP);
      check("rst_id_pc", id_pc, 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    drive();
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RST_PC);
    sample();
  endtask

  redir_vec_t tbl [5];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rnd       = 1'b0;
    hold_id   = 1'b0;
    mem_stall = 1'b0;
    force_pc  = 32'h0;

    tbl[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200};
    tbl[1] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100};
    tbl[2] = '{rpc: 32'h8000_0007, exp_addr: 32'h8000_0004};
    tbl[3] = '{rpc: 32'h1234_5679, exp_addr: 32'h1234_5678};
    tbl[4] = '{rpc: 32'hFFFF_FFF9, exp_addr: 32'hFFFF_FFF8};

    // in-order start with a 1-cycle memory
    do_reset();
    repeat (6) step();
    check("acc_count", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      check("acc0", acc_log[0], 32'h0);
      check("acc1", acc_log[1], 32'h4);
      check("acc2", acc_log[2], 32'h8);
    end
    check("hs_count", 32'(hs_pc.size() >= 2), 32'd1);
    if (hs_pc.size() >= 2) begin
      check("hs_pc0", hs_pc[0], 32'h0);
      check("hs_pc1", hs_pc[1], 32'h4);
      check("hs_back_to_back", hs_cyc[1] - hs_cyc[0], 32'd1);
    end

    // decode stall: buffer fills, fetch stops, nothing lost afterwards
    hold_id = 1'b1;
    repeat (5) step();
    check("full_idv", 32'(id_valid), 32'd1);
    check("full_no_req", 32'(imem_req_valid), 32'd0);
    hold_id = 1'b0;
    repeat (6) step();

    // redirect with two requests in flight: both late responses dropped
    do_reset();
    mem_stall = 1'b1;
    step();
    step();
    check("two_out_no_req", 32'(imem_req_valid), 32'd0);
    force_redir = 1'b1;
    force_pc    = 32'h0000_0100;
    step();
    mem_stall = 1'b0;
    hs_pc.delete();
    repeat (8) step();
    check("redir_hs_seen", 32'(hs_pc.size() != 0), 32'd1);
    if (hs_pc.size() != 0) check("redir_first_pc", hs_pc[0], 32'h0000_0100);

    // redirect alignment table; last entry runs across the 32-bit wrap
    foreach (tbl[i]) begin
      force_redir = 1'b1;
      force_pc    = tbl[i].rpc;
      step();
      step();
      check("redir_align", imem_req_addr, tbl[i].exp_addr);
      repeat (4) step();
    end

    // asynchronous reset while the buffer is full
    hold_id = 1'b1;
    repeat (6) step();
    check("pre_rst_full", 32'(id_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_idv", 32'(id_valid), 32'd0);
    check("rst_async_req", 32'(imem_req_valid), 32'd0);
    hold_id = 1'b0;
    do_reset();

    // randomized traffic against the model
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_bubble", perf_bubble, 32'(m_bubble));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
